// File: rtl/multiword_add_sequencer.sv
// Sequential wide adder: one N-bit ripple-carry adder reused over K chunks, LSB chunk first.
// Optional subtract mode enabled by defining ADDSEQ_SUB_EN (adds the 'sub' input port).

module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int unsigned i = 0; i < N; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[N];
endmodule

module multiword_add_sequencer #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
`ifdef ADDSEQ_SUB_EN
    input  logic           sub,
`endif
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           busy
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_sum;
    logic           r_carry;
    logic           r_cout;
    logic [IW-1:0]  r_idx;

    logic [N-1:0]   w_a_chunk;
    logic [N-1:0]   w_b_chunk;
    logic [N-1:0]   w_sum_chunk;
    logic           w_carry_out;
    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_b_in;
    logic           w_cin_in;

    // Subtraction is a + ~b + 1: invert b and force the chunk-0 carry on accept.
`ifdef ADDSEQ_SUB_EN
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_accept  = start_valid && (r_state == S_IDLE);
    assign w_last    = (r_idx == IW'(K - 1));
    assign w_a_chunk = r_a[r_idx*N +: N];
    assign w_b_chunk = r_b[r_idx*N +: N];

    ripple_carry_adder #(
        .N(N)
    ) u_rca (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_sum_chunk),
        .o_cout (w_carry_out)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*N +: N] <= w_sum_chunk;
                    r_carry             <= w_carry_out;
                    if (w_last) begin
                        r_cout <= w_carry_out;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum         = r_sum;
    assign cout        = r_cout;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Randomised self-checking bench for multiword_add_sequencer (N=4, K=4); model is plain W-bit arithmetic.
`timescale 1ns/1ps
module tb_multiword_add_sequencer;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    multiword_add_sequencer #(
        .N(N),
        .K(K)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef ADDSEQ_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
        logic [W:0] r;
`ifdef ADDSEQ_SUB_EN
        if (msub)
            r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        else
            r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
`else
        r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin) + (W+1)'(msub & 1'b0);
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job end to end: accept, latency, result, hold stability, return to IDLE.
    task automatic do_job(input string name, input logic [W-1:0] ja, input logic [W-1:0] jb,
                          input logic jcin, input logic jsub, input int hold);
        logic [W:0]   exp;
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           cyc;
        exp         = model(ja, jb, jcin, jsub);
        a           = ja;
        b           = jb;
        cin         = jcin;
        sub         = jsub;
        start_valid = 1'b1;
        res_ready   = (hold == 0);
        cyc = 0;
        while (!start_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept_timeout: start_ready=%b required 1", name, start_ready);
        end
        tick();
        start_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_run_flags: busy=%b start_ready=%b required 1 0", name, busy, start_ready);
        end
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 4*K + 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != K) begin
            failures++;
            $display("FAIL %s_latency: cycles=%0d required %0d", name, cyc, K);
        end
        checks++;
        if (sum !== exp[W-1:0] || cout !== exp[W]) begin
            failures++;
            $display("FAIL %s_result: sum=%h cout=%b required sum=%h cout=%b",
                     name, sum, cout, exp[W-1:0], exp[W]);
        end
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || sum !== held_sum || cout !== held_cout || start_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_hold: res_valid=%b sum=%h cout=%b start_ready=%b required 1 %h %b 0",
                         name, res_valid, sum, cout, start_ready, held_sum, held_cout);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: res_valid=%b start_ready=%b busy=%b required 0 1 0",
                     name, res_valid, start_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: start_ready=%b res_valid=%b busy=%b sum=%h cout=%b required 1 0 0 0000 0",
                     start_ready, res_valid, busy, sum, cout);
        end
    endtask

    task automatic test_directed();
        do_job("t1_basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        do_job("t2_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_job("t3_cin",     16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        do_job("t3_zero",    16'h0000, 16'h0000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1, b1, a2, b2;
        logic [W:0]   e1, e2;
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           cyc;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        e1 = model(a1, b1, 1'b1, 1'b0);
        e2 = model(a2, b2, 1'b0, 1'b0);
        a = a1; b = b1; cin = 1'b1; sub = 1'b0;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        tick();
        // Second job stays requested throughout RUN/DONE and must wait.
        a = a2; b = b2; cin = 1'b0;
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 4*K + 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (sum !== e1[W-1:0] || cout !== e1[W] || cyc != K) begin
            failures++;
            $display("FAIL bp_result: sum=%h cout=%b cycles=%0d required sum=%h cout=%b cycles=%0d",
                     sum, cout, cyc, e1[W-1:0], e1[W], K);
        end
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || sum !== held_sum || cout !== held_cout || start_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: res_valid=%b sum=%h cout=%b start_ready=%b required 1 %h %b 0",
                         res_valid, sum, cout, start_ready, held_sum, held_cout);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: start_ready=%b res_valid=%b required 1 0", start_ready, res_valid);
        end
        tick();
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accept: busy=%b start_ready=%b required 1 0", busy, start_ready);
        end
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 4*K + 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (sum !== e2[W-1:0] || cout !== e2[W] || cyc != K) begin
            failures++;
            $display("FAIL bp_second_result: sum=%h cout=%b cycles=%0d required sum=%h cout=%b cycles=%0d",
                     sum, cout, cyc, e2[W-1:0], e2[W], K);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        a = 16'hABCD; b = 16'h5678; cin = 1'b1; sub = 1'b0;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || start_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_run: res_valid=%b busy=%b sum=%h cout=%b start_ready=%b required 0 0 0000 0 1",
                     res_valid, busy, sum, cout, start_ready);
        end
        do_job("rst_new_job", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub();
        do_job("sub_borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_job("sub_noborrow",  16'h0007, 16'h0005, 1'b1, 1'b1, 1);
        do_job("sub_zero_cin0", 16'h0000, 16'h0000, 1'b0, 1'b1, 0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_job("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
